// File: rtl/tri_pkg.sv
// tri_pkg -- shared declarations for the triangle rasteriser.
//   state_t : controller states (IDLE, SETUP, SCAN, DRAIN)
//   bbox_t  : bounding-box record, held at the widest legal coordinate width
//   edge_w  : width of a signed edge value for a given coordinate width
//   min3 / max3 : three-way unsigned minimum / maximum over bbox-width values
package tri_pkg;

   localparam int MAX_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   typedef struct packed {
      logic [MAX_W-1:0] xmin;
      logic [MAX_W-1:0] xmax;
      logic [MAX_W-1:0] ymin;
      logic [MAX_W-1:0] ymax;
   } bbox_t;

   // Two (W+1)-bit signed differences multiplied give 2W+2 bits; the
   // difference of two such products needs one more.
   function automatic int edge_w(input int w);
      return 2*w + 3;
   endfunction

   function automatic logic [MAX_W-1:0] min3(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic [MAX_W-1:0] c);
      logic [MAX_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [MAX_W-1:0] max3(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic [MAX_W-1:0] c);
      logic [MAX_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage

// File: rtl/tri_raster_if.sv
// tri_raster_if -- triangle descriptor input and pixel output streams.
//   tri_valid/tri_ready + x1,y1,x2,y2,x3,y3 : descriptor handshake
//   pix_valid/pix_ready + pix_x,pix_y,pix_inside,pix_last : pixel stream
//   master : the environment (sends triangles, consumes pixels)
//   slave  : the rasteriser
interface tri_raster_if #(
   parameter int W = 11
);
   logic         tri_valid;
   logic         tri_ready;
   logic [W-1:0] x1, y1, x2, y2, x3, y3;
   logic         pix_valid;
   logic         pix_ready;
   logic [W-1:0] pix_x, pix_y;
   logic         pix_inside;
   logic         pix_last;

   modport master (
      output tri_valid, x1, y1, x2, y2, x3, y3, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y, pix_inside, pix_last
   );

   modport slave (
      input  tri_valid, x1, y1, x2, y2, x3, y3, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y, pix_inside, pix_last
   );
endinterface

// File: rtl/tri_edge.sv
// tri_edge -- combinational signed edge function for one triangle edge.
//   e = (bx-px)*(cy-py) - (cx-px)*(by-py), full precision.
//   bx,by,cx,cy : edge end points (unsigned, W bits)
//   px,py       : pixel under test (unsigned, W bits)
//   e           : signed edge value, edge_w(W) bits
module tri_edge
   import tri_pkg::*;
#(
   parameter int W = 11
) (
   input  logic [W-1:0]                 bx,
   input  logic [W-1:0]                 by,
   input  logic [W-1:0]                 cx,
   input  logic [W-1:0]                 cy,
   input  logic [W-1:0]                 px,
   input  logic [W-1:0]                 py,
   output logic signed [edge_w(W)-1:0]  e
);
   localparam int EW = edge_w(W);
   localparam int PW = 2*W + 2;

   logic signed [W:0]    dbx, dby, dcx, dcy;
   logic signed [PW-1:0] prod_a, prod_b;

   always_comb begin
      dbx    = $signed({1'b0, bx}) - $signed({1'b0, px});
      dby    = $signed({1'b0, by}) - $signed({1'b0, py});
      dcx    = $signed({1'b0, cx}) - $signed({1'b0, px});
      dcy    = $signed({1'b0, cy}) - $signed({1'b0, py});
      prod_a = PW'(dbx) * PW'(dcy);
      prod_b = PW'(dcx) * PW'(dby);
      e      = EW'(prod_a) - EW'(prod_b);
   end
endmodule

// File: rtl/tri_raster.sv
// tri_raster -- scans the bounding box of a triangle row-major, one pixel per
// cycle, tagging each pixel as inside or outside the triangle.
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   bus        : descriptor input and pixel output streams (slave side)
//   inside_cnt : inside pixels handed downstream for the current triangle
//   busy       : controller not idle
// Build option: define TRI_RASTER_EDGE_INCL_EN to count pixels lying on an
// edge or vertex as inside; by default only strictly interior pixels are.
module tri_raster
   import tri_pkg::*;
#(
   parameter int W  = 11,
   parameter int CW = 2*W
) (
   input  logic          clk,
   input  logic          rst,
   tri_raster_if.slave   bus,
   output logic [CW-1:0] inside_cnt,
   output logic          busy
);
   localparam int EW = edge_w(W);
   localparam int AW = 2*W + 2;

   state_t               state, state_nxt;
   logic [W-1:0]         vx1_p0, vy1_p0, vx2_p0, vy2_p0, vx3_p0, vy3_p0;
   bbox_t                bbox_p1, bbox_nxt;
   logic signed [AW-1:0] area_p1, area_nxt;
   logic signed [W:0]    dx2, dy2, dx3, dy3;
   logic [MAX_W-1:0]     cur_x, cur_y;
   logic                 accept, load, pix_hs, at_xmax, at_last;
   logic signed [EW-1:0] e12, e23, e31;
   logic                 all_pos, all_neg, px_inside;

   assign accept  = bus.tri_valid & bus.tri_ready;
   assign load    = !bus.pix_valid | bus.pix_ready;
   assign pix_hs  = bus.pix_valid & bus.pix_ready;
   assign at_xmax = (cur_x == bbox_p1.xmax);
   assign at_last = at_xmax && (cur_y == bbox_p1.ymax);

   // ---- controller: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // ---- controller: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept)         state_nxt = ST_SETUP;
         ST_SETUP:                     state_nxt = ST_SCAN;
         ST_SCAN:  if (load && at_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (pix_hs)         state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   // ---- controller: outputs
   always_comb begin
      bus.tri_ready = (state == ST_IDLE);
      busy          = (state != ST_IDLE);
   end

   // ---- setup arithmetic on the captured vertices
   always_comb begin
      bbox_nxt.xmin = min3(MAX_W'(vx1_p0), MAX_W'(vx2_p0), MAX_W'(vx3_p0));
      bbox_nxt.xmax = max3(MAX_W'(vx1_p0), MAX_W'(vx2_p0), MAX_W'(vx3_p0));
      bbox_nxt.ymin = min3(MAX_W'(vy1_p0), MAX_W'(vy2_p0), MAX_W'(vy3_p0));
      bbox_nxt.ymax = max3(MAX_W'(vy1_p0), MAX_W'(vy2_p0), MAX_W'(vy3_p0));
      dx2      = $signed({1'b0, vx2_p0}) - $signed({1'b0, vx1_p0});
      dy2      = $signed({1'b0, vy2_p0}) - $signed({1'b0, vy1_p0});
      dx3      = $signed({1'b0, vx3_p0}) - $signed({1'b0, vx1_p0});
      dy3      = $signed({1'b0, vy3_p0}) - $signed({1'b0, vy1_p0});
      area_nxt = AW'(dx2) * AW'(dy3) - AW'(dx3) * AW'(dy2);
   end

   // ---- stage p0: vertex capture; stage p1: bbox/area and scan position.
   // Pure datapath, so no reset; the controller decides when it is meaningful.
   always_ff @(posedge clk) begin
      if (accept) begin
         vx1_p0 <= bus.x1;
         vy1_p0 <= bus.y1;
         vx2_p0 <= bus.x2;
         vy2_p0 <= bus.y2;
         vx3_p0 <= bus.x3;
         vy3_p0 <= bus.y3;
      end
      if (state == ST_SETUP) begin
         bbox_p1 <= bbox_nxt;
         area_p1 <= area_nxt;
         cur_x   <= bbox_nxt.xmin;
         cur_y   <= bbox_nxt.ymin;
      end else if (state == ST_SCAN && load) begin
         if (at_xmax) begin
            cur_x <= bbox_p1.xmin;
            cur_y <= cur_y + MAX_W'(1);
         end else begin
            cur_x <= cur_x + MAX_W'(1);
         end
      end
   end

   tri_edge #(.W(W)) u_e12 (
      .bx(vx1_p0), .by(vy1_p0), .cx(vx2_p0), .cy(vy2_p0),
      .px(cur_x[W-1:0]), .py(cur_y[W-1:0]), .e(e12)
   );
   tri_edge #(.W(W)) u_e23 (
      .bx(vx2_p0), .by(vy2_p0), .cx(vx3_p0), .cy(vy3_p0),
      .px(cur_x[W-1:0]), .py(cur_y[W-1:0]), .e(e23)
   );
   tri_edge #(.W(W)) u_e31 (
      .bx(vx3_p0), .by(vy3_p0), .cx(vx1_p0), .cy(vy1_p0),
      .px(cur_x[W-1:0]), .py(cur_y[W-1:0]), .e(e31)
   );

   // Same-sign test over the three edges accepts either winding order.
   always_comb begin
`ifdef TRI_RASTER_EDGE_INCL_EN
      all_pos = !e12[EW-1] && !e23[EW-1] && !e31[EW-1];
      all_neg = (e12[EW-1] || e12 == '0) && (e23[EW-1] || e23 == '0) &&
                (e31[EW-1] || e31 == '0);
`else
      all_pos = !e12[EW-1] && (e12 != '0) && !e23[EW-1] && (e23 != '0) &&
                !e31[EW-1] && (e31 != '0);
      all_neg = e12[EW-1] && e23[EW-1] && e31[EW-1];
`endif
      px_inside = (area_p1 != '0) && (all_pos || all_neg);
   end

   // ---- stage p2: output register and inside counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.pix_valid  <= 1'b0;
         bus.pix_x      <= '0;
         bus.pix_y      <= '0;
         bus.pix_inside <= 1'b0;
         bus.pix_last   <= 1'b0;
         inside_cnt     <= '0;
      end else begin
         if (load) begin
            bus.pix_valid <= (state == ST_SCAN);
            if (state == ST_SCAN) begin
               bus.pix_x      <= cur_x[W-1:0];
               bus.pix_y      <= cur_y[W-1:0];
               bus.pix_inside <= px_inside;
               bus.pix_last   <= at_last;
            end
         end
         if (accept)
            inside_cnt <= '0;
         else if (pix_hs && bus.pix_inside)
            inside_cnt <= inside_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_tri_raster.sv
// tb_tri_raster -- bench for tri_raster: hand-derived vector table, reset and
// stall sequences, and random triangles against a bounding-box reference.
`timescale 1ns/1ps
module tb_tri_raster;
   localparam int W  = 11;
   localparam int CW = 2*W;
`ifdef TRI_RASTER_EDGE_INCL_EN
   localparam int INCL = 1;
`else
   localparam int INCL = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] inside_cnt;
   logic          busy;

   tri_raster_if #(.W(W)) bus ();

   tri_raster #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst_n),
      .bus       (bus),
      .inside_cnt(inside_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int ins;
      int last;
   } pix_t;

   // probe expectation -1 means the pixel must never be emitted
   typedef struct {
      int x1, y1, x2, y2, x3, y3;
      int n_pix, n_in;
      int fx, fy, f_in;
      int lx, ly;
      int pax, pay, pa_in;
      int pbx, pby, pb_in;
   } vec_t;

   pix_t exp_q[$];
   pix_t got_q[$];
   pix_t ref_q[$];
   int   exp_in;
   int   lat_seen;
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: a pixel is inside when it lies on the same side of all three
   // edges (strictly, or including the edge with the inclusive rule) and the
   // triangle has non-zero area.
   function automatic int model_in(int x1, int y1, int x2, int y2, int x3, int y3,
                                   int px, int py);
      int a, e1, e2, e3;
      a  = (x2 - x1) * (y3 - y1) - (x3 - x1) * (y2 - y1);
      e1 = (x1 - px) * (y2 - py) - (x2 - px) * (y1 - py);
      e2 = (x2 - px) * (y3 - py) - (x3 - px) * (y2 - py);
      e3 = (x3 - px) * (y1 - py) - (x1 - px) * (y3 - py);
      if (a == 0) return 0;
      if (INCL == 1)
         return ((e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0)) ? 1 : 0;
      return ((e1 > 0 && e2 > 0 && e3 > 0) || (e1 < 0 && e2 < 0 && e3 < 0)) ? 1 : 0;
   endfunction

   task automatic build_model(input int x1, input int y1, input int x2, input int y2,
                              input int x3, input int y3);
      int xmin, xmax, ymin, ymax;
      pix_t p;
      xmin = (x1 < x2) ? x1 : x2;  xmin = (x3 < xmin) ? x3 : xmin;
      xmax = (x1 > x2) ? x1 : x2;  xmax = (x3 > xmax) ? x3 : xmax;
      ymin = (y1 < y2) ? y1 : y2;  ymin = (y3 < ymin) ? y3 : ymin;
      ymax = (y1 > y2) ? y1 : y2;  ymax = (y3 > ymax) ? y3 : ymax;
      exp_q.delete();
      exp_in = 0;
      for (int y = ymin; y <= ymax; y++)
         for (int x = xmin; x <= xmax; x++) begin
            p.x    = x;
            p.y    = y;
            p.ins  = model_in(x1, y1, x2, y2, x3, y3, x, y);
            p.last = (x == xmax && y == ymax) ? 1 : 0;
            exp_in += p.ins;
            exp_q.push_back(p);
         end
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send_desc(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3);
      int guard = 0;
      bus.x1 = W'(x1); bus.y1 = W'(y1);
      bus.x2 = W'(x2); bus.y2 = W'(y2);
      bus.x3 = W'(x3); bus.y3 = W'(y3);
      bus.tri_valid = 1'b1;
      while (bus.tri_ready !== 1'b1 && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 2000) begin
         n_checks++; n_err++;
         $display("FAIL accept_timeout: tri_ready low for %0d cycles", guard);
      end
      @(posedge clk); #1;
      bus.tri_valid = 1'b0;
   endtask

   // Consume pixels until pix_last is handed over; optionally stall randomly
   // and present junk descriptors while busy.
   task automatic collect(input bit stall, input bit poke);
      int   cyc        = 0;
      int   first      = -1;
      bit   done       = 1'b0;
      bit   prev_stall = 1'b0;
      pix_t cur;
      pix_t prev;
      got_q.delete();
      while (!done && cyc < 4000) begin
         cur.x    = int'(bus.pix_x);
         cur.y    = int'(bus.pix_y);
         cur.ins  = int'(bus.pix_inside);
         cur.last = int'(bus.pix_last);
         if (prev_stall) begin
            n_checks++;
            if (bus.pix_valid !== 1'b1 || cur.x != prev.x || cur.y != prev.y ||
                cur.ins != prev.ins || cur.last != prev.last) begin
               n_err++;
               $display("FAIL stall_hold: got v=%0d (%0d,%0d) in=%0d last=%0d, held (%0d,%0d) in=%0d last=%0d",
                        bus.pix_valid, cur.x, cur.y, cur.ins, cur.last,
                        prev.x, prev.y, prev.ins, prev.last);
            end
         end
         if (first < 0 && bus.pix_valid === 1'b1) first = cyc;
         bus.pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke && busy) begin
            bus.tri_valid = 1'($urandom_range(0, 1));
            bus.x1 = W'($urandom_range(0, 40)); bus.y1 = W'($urandom_range(0, 40));
            bus.x2 = W'($urandom_range(0, 40)); bus.y2 = W'($urandom_range(0, 40));
            bus.x3 = W'($urandom_range(0, 40)); bus.y3 = W'($urandom_range(0, 40));
         end else begin
            bus.tri_valid = 1'b0;
         end
         prev       = cur;
         prev_stall = bus.pix_valid && !bus.pix_ready;
         if (bus.pix_valid && bus.pix_ready) begin
            got_q.push_back(cur);
            if (bus.pix_last) done = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.tri_valid = 1'b0;
      bus.pix_ready = 1'b0;
      if (!done) begin
         n_checks++; n_err++;
         $display("FAIL collect_timeout: %0d pixels after %0d cycles", got_q.size(), cyc);
      end
      lat_seen = first;
   endtask

   task automatic compare_model(input string tag);
      chk({tag, "_latency"}, lat_seen, 2);
      chk({tag, "_npix"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k].x != exp_q[k].x || got_q[k].y != exp_q[k].y ||
             got_q[k].ins != exp_q[k].ins || got_q[k].last != exp_q[k].last) begin
            n_err++;
            $display("FAIL %s_pix[%0d]: got (%0d,%0d) in=%0d last=%0d, expected (%0d,%0d) in=%0d last=%0d",
                     tag, k, got_q[k].x, got_q[k].y, got_q[k].ins, got_q[k].last,
                     exp_q[k].x, exp_q[k].y, exp_q[k].ins, exp_q[k].last);
         end
      end
      chk({tag, "_inside_cnt"}, inside_cnt, exp_in);
   endtask

   function automatic int probe(int px, int py);
      foreach (got_q[k])
         if (got_q[k].x == px && got_q[k].y == py) return got_q[k].ins;
      return -1;
   endfunction

   vec_t tbl[6];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, 0, 10, 0, 0, 10, 121, (INCL == 1) ? 66 : 36, 0, 0, INCL, 10, 10,
                 3, 3, 1, 5, 5, INCL};
      tbl[1] = '{15, 15, 30, 0, 15, 0, 256, (INCL == 1) ? 136 : 91, 15, 0, INCL, 30, 15,
                 20, 5, 1, 3, 3, -1};
      tbl[2] = '{0, 0, 5, 5, 10, 10, 121, 0, 0, 0, 0, 10, 10,
                 5, 5, 0, 3, 3, 0};
      tbl[3] = '{7, 7, 7, 7, 7, 7, 1, 0, 7, 7, 0, 7, 7,
                 7, 7, 0, 0, 0, -1};
      tbl[4] = '{0, 0, 4, 0, 0, 4, 25, (INCL == 1) ? 15 : 3, 0, 0, INCL, 4, 4,
                 1, 1, 1, 2, 2, INCL};
      tbl[5] = '{2, 4, 9, 4, 5, 4, 8, 0, 2, 4, 0, 9, 4,
                 5, 4, 0, 5, 5, -1};

      rst_n         = 1'b0;
      bus.tri_valid = 1'b0;
      bus.pix_ready = 1'b0;
      bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix_valid", bus.pix_valid, 0);
      chk("rst_pix_x", bus.pix_x, 0);
      chk("rst_pix_y", bus.pix_y, 0);
      chk("rst_pix_inside", bus.pix_inside, 0);
      chk("rst_pix_last", bus.pix_last, 0);
      chk("rst_inside_cnt", inside_cnt, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_tri_ready", bus.tri_ready, 1);

      // vector table
      for (int i = 0; i < 6; i++) begin
         int lastcnt;
         build_model(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].x3, tbl[i].y3);
         send_desc(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].x3, tbl[i].y3);
         collect(i % 2 == 1, i % 2 == 1);
         compare_model($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_npix_tbl", i), got_q.size(), tbl[i].n_pix);
         chk($sformatf("vec%0d_cnt_tbl", i), inside_cnt, tbl[i].n_in);
         if (got_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL vec%0d_empty: got 0 pixels, expected %0d", i, tbl[i].n_pix);
         end else begin
            chk($sformatf("vec%0d_first_x", i), got_q[0].x, tbl[i].fx);
            chk($sformatf("vec%0d_first_y", i), got_q[0].y, tbl[i].fy);
            chk($sformatf("vec%0d_first_in", i), got_q[0].ins, tbl[i].f_in);
            chk($sformatf("vec%0d_last_x", i), got_q[got_q.size()-1].x, tbl[i].lx);
            chk($sformatf("vec%0d_last_y", i), got_q[got_q.size()-1].y, tbl[i].ly);
         end
         lastcnt = 0;
         foreach (got_q[k]) lastcnt += got_q[k].last;
         chk($sformatf("vec%0d_last_flags", i), lastcnt, 1);
         chk($sformatf("vec%0d_probe_a", i), probe(tbl[i].pax, tbl[i].pay), tbl[i].pa_in);
         chk($sformatf("vec%0d_probe_b", i), probe(tbl[i].pbx, tbl[i].pby), tbl[i].pb_in);
         if (i == 0) ref_q = got_q;
      end

      // stalled, poked run of vector 0 must reproduce the unstalled sequence
      begin
         int diffs = 0;
         send_desc(0, 0, 10, 0, 0, 10);
         collect(1'b1, 1'b1);
         chk("stall_seq_len", got_q.size(), ref_q.size());
         for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
            if (got_q[k].x != ref_q[k].x || got_q[k].y != ref_q[k].y ||
                got_q[k].ins != ref_q[k].ins || got_q[k].last != ref_q[k].last)
               diffs++;
         chk("stall_seq_diffs", diffs, 0);
         chk("stall_seq_cnt", inside_cnt, (INCL == 1) ? 66 : 36);
      end

      // reset in the middle of a scan
      send_desc(0, 0, 10, 0, 0, 10);
      bus.pix_ready = 1'b1;
      repeat (60) begin
         @(posedge clk); #1;
      end
      chk("midrst_busy_before", busy, 1);
      chk("midrst_cnt_before_nonzero", (inside_cnt != 0) ? 1 : 0, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_pix_valid", bus.pix_valid, 0);
      chk("midrst_inside_cnt", inside_cnt, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_pix_x", bus.pix_x, 0);
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.pix_ready = 1'b0;
      @(posedge clk); #1;
      chk("midrst_pix_valid_after", bus.pix_valid, 0);
      chk("midrst_tri_ready_after", bus.tri_ready, 1);
      build_model(0, 0, 4, 0, 0, 4);
      send_desc(0, 0, 4, 0, 0, 4);
      collect(1'b0, 1'b0);
      compare_model("after_rst");

      // random triangles
      for (int r = 0; r < 20; r++) begin
         int c[6];
         bit st;
         foreach (c[j]) c[j] = int'($urandom_range(0, 12));
         st = 1'($urandom_range(0, 1));
         build_model(c[0], c[1], c[2], c[3], c[4], c[5]);
         send_desc(c[0], c[1], c[2], c[3], c[4], c[5]);
         collect(st, st);
         compare_model($sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
